// File: rtl/rotate_sweep_ctrl.sv
// Sequencer feeding a 16-bit barrel rotator: latches a pattern, then steps
// the rotate amount on a prescaled tick (continuous / ping-pong) or on
// explicit step pulses, so the rotator output animates.
module rotate_sweep_ctrl #(
    parameter int TICK_DIV = 50000000,
    parameter int DIV_W    = 26
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic [1:0]  mode,
    input  logic        step,
    input  logic        dir,
    input  logic [15:0] pattern_in,
    output logic [15:0] num,
    output logic [3:0]  amt,
    output logic        LR,
    output logic        busy,
    output logic        wrap
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] RUN       = 2'd1;
    localparam logic [1:0] STEP_WAIT = 2'd2;

    localparam logic [1:0] MODE_RIGHT = 2'b00;
    localparam logic [1:0] MODE_LEFT  = 2'b01;
    localparam logic [1:0] MODE_PING  = 2'b10;
    localparam logic [1:0] MODE_STEP  = 2'b11;

    localparam logic [DIV_W-1:0] TICK_LAST = DIV_W'(TICK_DIV - 1);

    logic [1:0]       state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [DIV_W-1:0] presc_q, presc_d;
    logic [15:0]      num_q, num_d;
    logic [3:0]       amt_q, amt_d;
    logic             lr_q, lr_d;
    logic             busy_q, busy_d;
    logic             wrap_q, wrap_d;
    logic             tick;

    // The prescaler reaching its last count marks one automatic advance.
    assign tick = (presc_q == TICK_LAST);

    // Next-state decode: stop beats start, start beats any advance.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        presc_d = presc_q;
        num_d   = num_q;
        amt_d   = amt_q;
        lr_d    = lr_q;
        busy_d  = busy_q;
        wrap_d  = 1'b0;

        if (stop) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            presc_d = '0;
        end else if (start) begin
            num_d   = pattern_in;
            amt_d   = 4'd0;
            presc_d = '0;
            mode_d  = mode;
            lr_d    = (mode == MODE_LEFT);
            busy_d  = 1'b1;
            state_d = (mode == MODE_STEP) ? STEP_WAIT : RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (tick) begin
                        presc_d = '0;
                        amt_d   = amt_q + 4'd1;
                        if (amt_q == 4'd15) begin
                            wrap_d = 1'b1;
                            if (mode_q == MODE_PING) begin
                                lr_d = ~lr_q;
                            end
                        end
                    end else begin
                        presc_d = presc_q + DIV_W'(1);
                    end
                end
                STEP_WAIT: begin
                    presc_d = '0;
                    if (step) begin
                        amt_d  = amt_q + 4'd1;
                        lr_d   = dir;
                        wrap_d = (amt_q == 4'd15);
                    end
                end
                default: begin
                    presc_d = '0;
                end
            endcase
        end
    end

    // State and output registers; reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mode_q  <= MODE_RIGHT;
            presc_q <= '0;
            num_q   <= 16'd0;
            amt_q   <= 4'd0;
            lr_q    <= 1'b0;
            busy_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            presc_q <= presc_d;
            num_q   <= num_d;
            amt_q   <= amt_d;
            lr_q    <= lr_d;
            busy_q  <= busy_d;
            wrap_q  <= wrap_d;
        end
    end

    assign num  = num_q;
    assign amt  = amt_q;
    assign LR   = lr_q;
    assign busy = busy_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_rotate_sweep_ctrl.sv
// Bench for rotate_sweep_ctrl: two instances (TICK_DIV=4 and TICK_DIV=1)
// share one set of inputs and are compared every cycle against a
// cycle-count based reference model, with directed and random stimulus.
module tb_rotate_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        startS = 1'b0;
    logic        stopS = 1'b0;
    logic [1:0]  modeS = 2'b00;
    logic        stepS = 1'b0;
    logic        dirS = 1'b0;
    logic [15:0] patS = 16'h0000;

    logic [15:0] numA, numB;
    logic [3:0]  amtA, amtB;
    logic        lrA, lrB, busyA, busyB, wrapA, wrapB;

    int total = 0;
    int bad = 0;

    // Reference model state, index 0 = TICK_DIV 4, index 1 = TICK_DIV 1.
    int          mState [2];
    int          mMode  [2];
    int          mCyc   [2];
    int          mAmt   [2];
    logic [15:0] mNum   [2];
    logic        mLR    [2];
    logic        mBusy  [2];
    logic        mWrap  [2];

    rotate_sweep_ctrl #(.TICK_DIV(4)) dutA (
        .clk(clk), .rst_n(rstN), .start(startS), .stop(stopS), .mode(modeS),
        .step(stepS), .dir(dirS), .pattern_in(patS),
        .num(numA), .amt(amtA), .LR(lrA), .busy(busyA), .wrap(wrapA)
    );

    rotate_sweep_ctrl #(.TICK_DIV(1)) dutB (
        .clk(clk), .rst_n(rstN), .start(startS), .stop(stopS), .mode(modeS),
        .step(stepS), .dir(dirS), .pattern_in(patS),
        .num(numB), .amt(amtB), .LR(lrB), .busy(busyB), .wrap(wrapB)
    );

    // Free-running 100 MHz style clock.
    always #5 clk = ~clk;

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            mState[k] = 0; mMode[k] = 0; mCyc[k] = 0; mAmt[k] = 0;
            mNum[k] = 16'h0; mLR[k] = 1'b0; mBusy[k] = 1'b0; mWrap[k] = 1'b0;
        end
    endtask

    // One clock edge of the behavioural model, driven by cycles spent in RUN.
    task automatic modelEdge(input int k);
        int div;
        div = (k == 0) ? 4 : 1;
        mWrap[k] = 1'b0;
        if (stopS) begin
            mState[k] = 0;
            mBusy[k]  = 1'b0;
        end else if (startS) begin
            mNum[k]   = patS;
            mAmt[k]   = 0;
            mLR[k]    = (modeS == 2'b01);
            mMode[k]  = int'(modeS);
            mState[k] = (modeS == 2'b11) ? 2 : 1;
            mBusy[k]  = 1'b1;
            mCyc[k]   = 0;
        end else if (mState[k] == 1) begin
            mCyc[k]++;
            if (mCyc[k] % div == 0) begin
                if (mAmt[k] == 15) begin
                    mWrap[k] = 1'b1;
                    if (mMode[k] == 2) mLR[k] = ~mLR[k];
                end
                mAmt[k] = (mAmt[k] + 1) % 16;
            end
        end else if (mState[k] == 2 && stepS) begin
            mWrap[k] = (mAmt[k] == 15);
            mAmt[k]  = (mAmt[k] + 1) % 16;
            mLR[k]   = dirS;
        end
    endtask

    task automatic checkValue(input string tag, input logic [22:0] obs, input logic [22:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare both instances against the model.
    task automatic checkOutput(input string tag);
        checkValue({tag, "/div4"}, {numA, amtA, lrA, busyA, wrapA},
                   {mNum[0], 4'(mAmt[0]), mLR[0], mBusy[0], mWrap[0]});
        checkValue({tag, "/div1"}, {numB, amtB, lrB, busyB, wrapB},
                   {mNum[1], 4'(mAmt[1]), mLR[1], mBusy[1], mWrap[1]});
    endtask

    task automatic applyStimulus(input logic st, input logic sp, input logic [1:0] md,
                                 input logic stp, input logic d, input logic [15:0] pat);
        startS = st; stopS = sp; modeS = md; stepS = stp; dirS = d; patS = pat;
    endtask

    // Advance one edge, update the model, check #1 later, drop pulses.
    task automatic tickCycle(input string tag);
        @(posedge clk);
        modelEdge(0);
        modelEdge(1);
        #1;
        checkOutput(tag);
        startS = 1'b0; stopS = 1'b0; stepS = 1'b0;
    endtask

    initial begin
        int wc;
        modelReset();
        #2;
        checkOutput("reset");
        #10 rstN = 1'b1;
        #1;

        // Continuous right, exactly one wrap per 64 cycles at TICK_DIV 4.
        applyStimulus(1, 0, 2'b00, 0, 0, 16'h0001);
        tickCycle("startRight");
        wc = 0;
        for (int i = 0; i < 64; i++) begin
            tickCycle("runRight");
            wc += int'(wrapA);
        end
        checkValue("wrapCount64", 23'(wc), 23'd1);

        // Asynchronous reset mid-run once amt reaches 7.
        for (int i = 0; i < 100 && mAmt[0] != 7; i++) tickCycle("toSeven");
        #3 rstN = 1'b0;
        #1;
        modelReset();
        checkOutput("asyncReset");
        #2 rstN = 1'b1;
        tickCycle("afterReset");

        // Ping-pong: LR flips on each revolution.
        applyStimulus(1, 0, 2'b10, 0, 0, 16'h00F0);
        tickCycle("startPing");
        for (int i = 0; i < 140; i++) tickCycle("runPing");

        // Continuous left: LR stays 1.
        applyStimulus(1, 0, 2'b01, 0, 1, 16'h8001);
        tickCycle("startLeft");
        for (int i = 0; i < 70; i++) tickCycle("runLeft");
        checkValue("leftLR", 23'(lrA), 23'd1);

        // Single-step: dir 1,1,0 then idle, then 13 more steps for one wrap.
        applyStimulus(1, 0, 2'b11, 0, 0, 16'h0F0F);
        tickCycle("startStep");
        applyStimulus(0, 0, 2'b00, 1, 1, 16'h0000); tickCycle("step1");
        applyStimulus(0, 0, 2'b00, 1, 1, 16'h0000); tickCycle("step2");
        applyStimulus(0, 0, 2'b00, 1, 0, 16'h0000); tickCycle("step3");
        checkValue("stepAmt3", 23'({amtA, lrA}), 23'({4'd3, 1'b0}));
        for (int i = 0; i < 100; i++) begin
            dirS = 1'($urandom);
            tickCycle("stepIdle");
        end
        wc = 0;
        for (int i = 0; i < 13; i++) begin
            applyStimulus(0, 0, 2'b10, 1, 1'(i), 16'h1234);
            tickCycle("stepMore");
            wc += int'(wrapA);
        end
        checkValue("stepWrap", 23'(wc), 23'd1);

        // Start and step together: start wins.
        applyStimulus(0, 0, 2'b11, 1, 1, 16'h0000); tickCycle("stepBefore");
        applyStimulus(1, 0, 2'b11, 1, 1, 16'h5555); tickCycle("startBeatsStep");

        // Stop at amt 5 then hold; start+stop in IDLE stays idle.
        applyStimulus(1, 0, 2'b00, 0, 0, 16'h0003);
        tickCycle("startForStop");
        for (int i = 0; i < 100 && mAmt[0] != 5; i++) tickCycle("toFive");
        applyStimulus(0, 1, 2'b00, 0, 0, 16'h0000);
        tickCycle("stop");
        for (int i = 0; i < 50; i++) tickCycle("holdFive");
        checkValue("holdAmt5", 23'({amtA, busyA}), 23'({4'd5, 1'b0}));
        applyStimulus(1, 1, 2'b01, 0, 0, 16'hFFFF);
        tickCycle("startStopIdle");
        for (int i = 0; i < 5; i++) tickCycle("stayIdle");

        // Restart mid-run at amt 9.
        applyStimulus(1, 0, 2'b00, 0, 0, 16'h0101);
        tickCycle("startForRestart");
        for (int i = 0; i < 100 && mAmt[0] != 9; i++) tickCycle("toNine");
        applyStimulus(1, 0, 2'b01, 0, 0, 16'hA5A5);
        tickCycle("restart");
        checkValue("restartVals", 23'({numA, amtA, lrA}), 23'({16'hA5A5, 4'd0, 1'b1}));
        for (int i = 0; i < 8; i++) tickCycle("afterRestart");

        // Stop landing on a tick edge must not advance.
        for (int i = 0; i < 10 && (mCyc[0] % 4) != 3; i++) tickCycle("alignTick");
        applyStimulus(0, 1, 2'b00, 0, 0, 16'h0000);
        tickCycle("stopOnTick");

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 79) == 0),
                          2'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom),
                          16'($urandom));
            tickCycle("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rotate_sweep_ctrl.md
Name: rotate_sweep_ctrl

Overview:
Sequencer that sits directly upstream of the 16-bit multifunction barrel rotator and drives its num, amt and LR inputs. It latches a 16-bit pattern and steps the rotate amount at a programmable tick rate, or one step per pulse, so the rotator output animates, for example on LEDs. It supports continuous right, continuous left, ping-pong (direction alternates each revolution) and single-step modes.

Parameters:
TICK_DIV, 50000000, clock cycles per automatic step; legal range 1..2^DIV_W
DIV_W, 26, prescaler counter width

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse: latch pattern/mode, begin sequence
stop  input  1  one-cycle pulse: end sequence, return to IDLE
mode  input  2  00 cont-right, 01 cont-left, 10 ping-pong, 11 single-step; sampled only on start
step  input  1  one-cycle pulse: advance one position (mode 11 only)
dir  input  1  single-step direction, 1=left; sampled on each accepted step
pattern_in  input  16  pattern to rotate; sampled only on start
num  output  16  registered pattern to rotator
amt  output  4  registered rotate amount to rotator
LR  output  1  registered direction to rotator, 1=left
busy  output  1  high in RUN or STEP_WAIT
wrap  output  1  one-cycle pulse when amt goes 15->0

Behaviour:
- Reset: num=0, amt=0, LR=0, busy=0, wrap=0, state=IDLE, prescaler=0, latched mode=00. Reset mid-sequence aborts immediately.
- All outputs are registered. No combinational path from any input to any output.
- States are IDLE, RUN and STEP_WAIT.
- IDLE, start=1 (and stop=0), on the next edge:
  - num<=pattern_in, amt<=0, prescaler<=0, mode latched.
  - LR<=1 for mode 01, else 0.
  - Go to RUN for modes 00/01/10; go to STEP_WAIT for mode 11.
  - busy=1 from that edge.
- stop has priority over start and step in every state. On stop: go to IDLE, busy<=0. num, amt and LR hold their last values.
- start while RUN or STEP_WAIT restarts the sequence exactly as from IDLE, re-latching pattern and mode. No IDLE cycle is inserted.
- RUN:
  - Prescaler counts 0..TICK_DIV-1 and wraps.
  - tick = (prescaler==TICK_DIV-1). With TICK_DIV=1, tick is asserted every cycle.
  - On tick: amt<=amt+1, modulo 16.
  - On a tick with amt==15: amt<=0 and wrap=1 for exactly that next cycle. In mode 10 only, LR<=~LR on the same edge.
  - The first tick occurs TICK_DIV cycles after entering RUN.
  - step and dir are ignored.
- STEP_WAIT:
  - Prescaler is held at 0.
  - On step: amt<=amt+1 modulo 16 and LR<=dir on the same edge.
  - On step with amt==15: wrap pulse.
  - step pulses on consecutive cycles each advance by one. A step held high for N cycles advances N times; the bench drives 1-cycle pulses.
- wrap defaults to 0 on every cycle not described above.
- Mode, pattern_in and dir changes outside their sampling points have no effect.
- Simultaneous start and step in STEP_WAIT: start wins and amt=0.
- Simultaneous stop and tick: no advance.

Test Plan:
- Reset: assert rst_n=0 asynchronously mid-RUN with amt=7 -> all outputs 0 immediately; state IDLE after release.
- TICK_DIV=4, mode=00, pattern_in=16'h0001, pulse start -> num=0001, LR=0, busy=1; amt steps 0,1,2,...,15 every 4 cycles; 0 follows 15 with a one-cycle wrap=1; exactly one wrap per 64 cycles.
- TICK_DIV=4, mode=10 -> LR=0 for amt 0..15, then LR=1 from the wrap edge; toggles back after the next 64 cycles; LR=1 on start for mode=01 and never toggles.
- Mode=11 with 3 step pulses, dir=1,1,0 -> amt=1,2,3 and LR=1,1,0. No change without step over 100 cycles. 16 steps total gives one wrap.
- Mode=00 run to amt=5, pulse stop -> busy=0, amt holds 5 indefinitely. Pulse start and stop together in IDLE -> stays IDLE.
- Restart mid-run (amt=9) with pattern_in=16'hA5A5, mode=01 -> next edge num=A5A5, amt=0, LR=1, prescaler restarts (first advance 4 cycles later). TICK_DIV=1 -> amt advances every cycle.
